// File: rtl/fetch_unit.sv
// Instruction fetch stage: program counter, prefetch FIFO and decode handshake with redirect flush.
// Defining FETCH_ALIGN_CHECK_EN adds a sticky misaligned-redirect FAULT state.
module fetch_unit #(
   parameter int unsigned ADDR_W    = 20,
   parameter int unsigned RESET_PC  = 0,
   parameter int unsigned MEM_BYTES = 100,
   parameter int unsigned DEPTH     = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [31:0]       imem_rdata,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              ins_valid,
   input  logic              ins_ready,
   output logic [31:0]       ins_data,
   output logic [ADDR_W-1:0] ins_pc,
   output logic              fault,
   output logic [ADDR_W-1:0] fault_pc
);

   localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
   localparam int unsigned DATA_W = 32;

   localparam logic [ADDR_W-1:0] LAST_PC  = ADDR_W'(MEM_BYTES - 4);
   localparam logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(4);
   localparam logic [ADDR_W-1:0] PC_RESET = ADDR_W'(RESET_PC);
   localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
`ifdef FETCH_ALIGN_CHECK_EN
      ST_FAULT = 2'd2,
`endif
      ST_END   = 2'd1
   } state_e;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   pc_q;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
   logic                valid_q;
   logic [ADDR_W-1:0]   pc_mem   [DEPTH];
   logic [DATA_W-1:0]   data_mem [DEPTH];

   logic                redir_c;
   logic                misalign_c;
   logic [ADDR_W-1:0]   target_c;
   logic                in_range_c;
   logic                pop_c;
   logic                room_c;
   logic                push_c;
   logic                flush_c;
   logic                load_pc_c;

   // Redirect qualification and target alignment
`ifdef FETCH_ALIGN_CHECK_EN
   logic                set_fault_c;
   logic                fault_q;
   logic [ADDR_W-1:0]   fault_pc_q;

   assign redir_c    = redirect_valid && (state_q != ST_FAULT);
   assign misalign_c = (redirect_pc[1:0] != 2'b00);
   assign target_c   = redirect_pc;
`else
   logic                unused_pc_lsb;

   assign redir_c       = redirect_valid;
   assign misalign_c    = 1'b0;
   assign target_c      = {redirect_pc[ADDR_W-1:2], 2'b00};
   assign unused_pc_lsb = ^redirect_pc[1:0];
`endif

   assign in_range_c = (pc_q <= LAST_PC);
   assign pop_c      = valid_q && ins_ready;
   assign room_c     = (cnt_q < FULL_CNT) || pop_c;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_RUN;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; a redirect overrides the end-of-memory transition
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RUN:  if (!in_range_c) state_d = ST_END;
         default: state_d = state_q;
      endcase
      if (redir_c) begin
         state_d = ST_RUN;
`ifdef FETCH_ALIGN_CHECK_EN
         if (misalign_c) state_d = ST_FAULT;
`endif
      end
   end

   // Control outputs of the FSM
   always_comb begin
      push_c    = 1'b0;
      flush_c   = 1'b0;
      load_pc_c = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      set_fault_c = 1'b0;
`endif
      case (state_q)
         ST_RUN:  push_c = in_range_c && room_c && !redir_c;
         default: push_c = 1'b0;
      endcase
      if (redir_c) begin
         flush_c   = 1'b1;
         load_pc_c = !misalign_c;
`ifdef FETCH_ALIGN_CHECK_EN
         set_fault_c = misalign_c;
`endif
      end
   end

   // FIFO occupancy and pointers; a flush wins over any push or pop
   always_comb begin
      cnt_d    = cnt_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (flush_c) begin
         cnt_d    = '0;
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         case ({push_c, pop_c})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
         endcase
      end
   end

   // Program counter, occupancy and valid flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q     <= PC_RESET;
         cnt_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         valid_q  <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         valid_q  <= (cnt_d != '0);
         if (load_pc_c) begin
            pc_q <= target_c;
         end else if (push_c) begin
            pc_q <= pc_q + PC_STEP;
         end
      end
   end

   // Prefetch storage; entries reset to zero so the idle head reads as zero
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            pc_mem[i]   <= '0;
            data_mem[i] <= '0;
         end
      end else if (push_c) begin
         pc_mem[wr_ptr_q]   <= pc_q;
         data_mem[wr_ptr_q] <= imem_rdata;
      end
   end

`ifdef FETCH_ALIGN_CHECK_EN
   // Sticky fault capture; only reset clears it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fault_q    <= 1'b0;
         fault_pc_q <= '0;
      end else if (set_fault_c) begin
         fault_q    <= 1'b1;
         fault_pc_q <= redirect_pc;
      end
   end

   assign fault    = fault_q;
   assign fault_pc = fault_pc_q;
`else
   assign fault    = 1'b0;
   assign fault_pc = '0;
`endif

   assign imem_addr = pc_q;
   assign ins_valid = valid_q;
   assign ins_data  = data_mem[rd_ptr_q];
   assign ins_pc    = pc_mem[rd_ptr_q];

endmodule
